dlx_sequencer: RTL and testbench
================================

// Module: dlx_sequencer
// PURPOSE
//  Multi-cycle control FSM for the DLX core. Sequences fetch, decode (drives decoder ID strobe),
//  execute, memory and writeback; runs valid/ready handshakes to instruction and data memory.
//  Adds a wait-state timeout with a sticky bus error and a retired-instruction counter.
// PARAMETERS
//  TIMEOUT  16  max wait cycles on i_ready/d_ready before ERROR; 0 disables the timeout
//  CNT_W    32  width of instr_retired
// PORTS
//  clk             in   1      clock; everything on posedge
//  reset_n         in   1      asynchronous active-low reset
//  run             in   1      1 = execute; 0 = park in IDLE at the next instruction boundary
//  i_ready         in   1      instruction memory ack for i_req
//  d_ready         in   1      data memory ack for d_req
//  d_load_enable   in   1      from decoder: current instruction is a load
//  d_write_enable  in   1      from decoder: current instruction is a store
//  Rd              in   5      from decoder: destination register
//  i_req           out  1      instruction fetch request
//  ir_load         out  1      1-cycle pulse: latch i_data_read into decoder input
//  ID              out  1      1-cycle decode strobe to decoder
//  ex_en           out  1      1-cycle ALU/branch evaluate strobe
//  pc_write_enable out  1      1-cycle PC update strobe
//  d_req           out  1      data memory request
//  d_we            out  1      data write qualifier, valid while d_req=1
//  reg_write       out  1      register-file write strobe
//  bus_error       out  1      sticky timeout flag
//  instr_retired   out  CNT_W  completed-instruction count, wraps
// BEHAVIOUR
//  Reset (async, any state, mid-handshake included): state=IDLE, all outputs 0, counters 0.
//  Outputs are Moore-decoded from registered state, except ir_load (= FETCH & i_ready).
//  IDLE:   all strobes 0. run=1 -> FETCH next cycle.
//  FETCH:  i_req=1 until i_ready. On i_ready: ir_load=1 that cycle -> DECODE.
//  DECODE: ID=1 for exactly 1 cycle -> EXEC.
//  EXEC:   ex_en=1, pc_write_enable=1 for 1 cycle. Decoder outputs are sampled here:
//          load|store -> MEM; else Rd!=0 -> WB; else instruction complete.
//  MEM:    d_req=1, d_we=d_write_enable. Signals are held stable until d_ready.
//          On d_ready: load -> WB; store -> complete.
//  WB:     reg_write=1 iff Rd!=0 for 1 cycle -> complete.
//  Complete: instr_retired+1 (modulo 2^CNT_W). Next state is FETCH if run=1, else IDLE.
//  run is ignored mid-instruction; deassertion only takes effect at completion.
//  i_ready/d_ready arriving while the matching req=0 are ignored.
//  Minimum latency: 4 cycles per ALU instruction (i_ready in the first FETCH cycle),
//  5 cycles per load, 4 per store, 3 per instruction with Rd=0.
//  Timeout:
//   - wait counter clears on every state change and counts each FETCH/MEM cycle without ready.
//   - If the counter reaches TIMEOUT with no ready: ERROR, bus_error=1.
//   - ready in the same cycle as expiry wins: no error.
//  ERROR: all strobes 0, bus_error=1, retired count frozen; exit only via reset_n.
//  No outputs are ever X after reset. One-hot strobes are mutually exclusive, except
//  ex_en/pc_write_enable (paired) and ir_load/i_req (overlap on the ack cycle).
// STRUCTURE
//  dlx_pkg: typedef enum seq_state_t {IDLE, FETCH, DECODE, EXEC, MEM, WB, ERROR};
//           localparam REG_ZERO = 5'd0.
//  Sub-module dlx_wait_timer (clear, count, expired; parameter TIMEOUT) is instantiated once.
//  Rest of block: state register, next-state logic, output decode, retired counter.
// TESTING
//  1 ALU op (Rd=3), i_ready in the first FETCH cycle, run=1 -> ID/ex_en/reg_write pulse at
//    cycles 2/3/4; instr_retired=1; back in FETCH at cycle 5.
//  2 Load (Rd=5), d_ready after 3 wait cycles -> d_req high 4 cycles, d_we=0;
//    reg_write 1 cycle after d_ready.
//  3 Store, d_ready immediate -> d_we=1 with d_req; reg_write never set; FETCH follows MEM.
//  4 TIMEOUT=4, i_ready held 0 -> ERROR after 4 FETCH cycles, bus_error=1 sticky;
//    i_ready afterwards has no effect; reset_n=0 clears to IDLE.
//  5 i_ready arrives exactly on the expiry cycle -> no error, DECODE next.
//  6 run dropped during MEM -> instruction completes, then IDLE;
//    async reset mid-MEM -> d_req=0 immediately.

Source files
------------

// File: rtl/dlx_pkg.sv
// Shared types for the DLX multi-cycle sequencer: FSM state encoding and the
// decoder fields captured in EXEC.
package dlx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        ERROR
    } seq_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic load;
        logic store;
        logic rd_nz;
    } instr_info_t;

endpackage

// File: rtl/dlx_sequencer_if.sv
// Valid/ready handshakes between the sequencer and instruction/data memory.
interface dlx_sequencer_if;

    logic i_req;
    logic i_ready;
    logic d_req;
    logic d_we;
    logic d_ready;

    modport master (
        output i_req,
        output d_req,
        output d_we,
        input  i_ready,
        input  d_ready
    );

    modport slave (
        input  i_req,
        input  d_req,
        input  d_we,
        output i_ready,
        output d_ready
    );

endinterface

// File: rtl/dlx_wait_timer.sv
// Wait-state counter: expired flags the TIMEOUT-th consecutive cycle spent
// waiting for a memory ack. TIMEOUT=0 disables it.
module dlx_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic count,
    output logic expired
);

    generate
        if (TIMEOUT == 0) begin : g_off
            assign expired = 1'b0;
        end else begin : g_on
            localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
            localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

            logic [CW-1:0] cnt;

            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt <= '0;
                end else if (clear) begin
                    cnt <= '0;
                end else if (count && (cnt != LAST)) begin
                    cnt <= cnt + CW'(1);
                end
            end

            // Counter holds the number of earlier wait cycles, so this cycle is the last allowed one.
            assign expired = count && (cnt == LAST);
        end
    endgenerate

endmodule

// File: rtl/dlx_sequencer.sv
// Multi-cycle DLX control FSM: fetch/decode/execute/memory/writeback with
// memory handshakes, wait-state timeout and a retired-instruction counter.
module dlx_sequencer
    import dlx_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              run,
    input  logic              d_load_enable,
    input  logic              d_write_enable,
    input  logic [4:0]        Rd,
    dlx_sequencer_if.master   bus,
    output logic              ir_load,
    output logic              ID,
    output logic              ex_en,
    output logic              pc_write_enable,
    output logic              reg_write,
    output logic              bus_error,
    output logic [CNT_W-1:0]  instr_retired
);

    seq_state_t  state, next_state;
    instr_info_t info, info_next;
    logic        retire;
    logic        waiting;
    logic        ready;
    logic        expired;

    dlx_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (next_state != state),
        .count   (waiting && !ready),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            info          <= '0;
            instr_retired <= '0;
        end else begin
            state <= next_state;
            info  <= info_next;
            if (retire) begin
                instr_retired <= instr_retired + CNT_W'(1);
            end
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        next_state = state;
        info_next  = info;
        retire     = 1'b0;
        waiting    = 1'b0;
        ready      = 1'b0;

        case (state)
            IDLE: begin
                if (run) next_state = FETCH;
            end
            FETCH: begin
                waiting = 1'b1;
                ready   = bus.i_ready;
                if (bus.i_ready)  next_state = DECODE;
                else if (expired) next_state = ERROR;
            end
            DECODE: next_state = EXEC;
            EXEC: begin
                // Decoder outputs are captured here and held for MEM/WB.
                info_next.load  = d_load_enable;
                info_next.store = d_write_enable;
                info_next.rd_nz = (Rd != REG_ZERO);
                if (d_load_enable || d_write_enable) next_state = MEM;
                else if (Rd != REG_ZERO)             next_state = WB;
                else                                 retire     = 1'b1;
            end
            MEM: begin
                waiting = 1'b1;
                ready   = bus.d_ready;
                if (bus.d_ready) begin
                    if (info.load) next_state = WB;
                    else           retire     = 1'b1;
                end else if (expired) begin
                    next_state = ERROR;
                end
            end
            WB:      retire     = 1'b1;
            ERROR:   next_state = ERROR;
            default: next_state = IDLE;
        endcase

        // Instruction boundary is the only point where run is honoured.
        if (retire) next_state = run ? FETCH : IDLE;
    end

    always_comb begin
        bus.i_req       = (state == FETCH);
        ir_load         = (state == FETCH) && bus.i_ready;
        ID              = (state == DECODE);
        ex_en           = (state == EXEC);
        pc_write_enable = (state == EXEC);
        bus.d_req       = (state == MEM);
        bus.d_we        = (state == MEM) && info.store;
        reg_write       = (state == WB) && info.rd_nz;
        bus_error       = (state == ERROR);
    end

endmodule

// File: tb/tb_dlx_sequencer.sv
// Self-checking bench: randomized instruction mix expanded into a per-cycle
// expected-output trace from the sequencing rules, plus timeout and reset cases.
module tb_dlx_sequencer;

    localparam int TIMEOUT    = 4;
    localparam int CNT_W      = 4;
    localparam int ERR_CYCLES = 5;

    // Observed output vector: {i_req, ir_load, ID, ex_en, pc_we, d_req, d_we, reg_write, bus_error}
    localparam logic [8:0] O_IREQ = 9'h100;
    localparam logic [8:0] O_IRLD = 9'h080;
    localparam logic [8:0] O_ID   = 9'h040;
    localparam logic [8:0] O_EXPC = 9'h030;
    localparam logic [8:0] O_DREQ = 9'h008;
    localparam logic [8:0] O_DWE  = 9'h004;
    localparam logic [8:0] O_RW   = 9'h002;
    localparam logic [8:0] O_BERR = 9'h001;

    typedef struct {
        logic       run;
        logic       i_rdy;
        logic       d_rdy;
        logic       ld;
        logic       st;
        logic [4:0] rd;
        logic [8:0] outs;
        int         cnt;
    } step_t;

    step_t q[$];
    int errors  = 0;
    int checks  = 0;
    int exp_cnt = 0;
    int step_no = 0;
    logic       cur_ld = 1'b0;
    logic       cur_st = 1'b0;
    logic [4:0] cur_rd = 5'd0;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic run = 1'b0;
    logic d_load_enable = 1'b0;
    logic d_write_enable = 1'b0;
    logic [4:0] Rd = 5'd0;
    logic ir_load, ID, ex_en, pc_write_enable, reg_write, bus_error;
    logic [CNT_W-1:0] instr_retired;
    logic [8:0] obs;

    dlx_sequencer_if bus ();

    dlx_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .run             (run),
        .d_load_enable   (d_load_enable),
        .d_write_enable  (d_write_enable),
        .Rd              (Rd),
        .bus             (bus),
        .ir_load         (ir_load),
        .ID              (ID),
        .ex_en           (ex_en),
        .pc_write_enable (pc_write_enable),
        .reg_write       (reg_write),
        .bus_error       (bus_error),
        .instr_retired   (instr_retired)
    );

    always #5 clk = ~clk;

    assign obs = {bus.i_req, ir_load, ID, ex_en, pc_write_enable,
                  bus.d_req, bus.d_we, reg_write, bus_error};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        assert (got === expv) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic pick_run(input int m);
        logic b;
        b = (m == 2) ? rnd() : (m != 0);
        return b;
    endfunction

    task automatic push(input logic r, input logic ir, input logic dr, input logic [8:0] o);
        step_t s;
        s.run = r; s.i_rdy = ir; s.d_rdy = dr;
        s.ld = cur_ld; s.st = cur_st; s.rd = cur_rd;
        s.outs = o; s.cnt = exp_cnt;
        q.push_back(s);
    endtask

    task automatic start_idle();
        push(1'b1, rnd(), rnd(), 9'h000);
    endtask

    // Instruction boundary: count advances; run=0 parks in IDLE until run returns.
    task automatic complete(input bit run_next);
        exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
        if (!run_next) begin
            for (int k = 0; k < 1 + int'($urandom_range(0, 2)); k++) push(1'b0, rnd(), rnd(), 9'h000);
            push(1'b1, rnd(), rnd(), 9'h000);
        end
    endtask

    task automatic push_error();
        for (int k = 0; k < ERR_CYCLES; k++) push(rnd(), 1'b1, 1'b1, O_BERR);
    endtask

    // kind: 0 ALU, 1 load, 2 store. fw/mw: wait cycles before ready (>= TIMEOUT -> ERROR).
    task automatic gen_instr(input int kind, input int rd, input int fw, input int mw,
                             input bit run_next, input int mid_run);
        logic [8:0] mem_o;
        cur_ld = (kind == 1);
        cur_st = (kind == 2);
        cur_rd = rd[4:0];
        if (fw >= TIMEOUT) begin
            for (int i = 0; i < TIMEOUT; i++) push(pick_run(mid_run), 1'b0, rnd(), O_IREQ);
            push_error();
            return;
        end
        for (int i = 0; i < fw; i++) push(pick_run(mid_run), 1'b0, rnd(), O_IREQ);
        push(pick_run(mid_run), 1'b1, rnd(), O_IREQ | O_IRLD);
        push(pick_run(mid_run), rnd(), rnd(), O_ID);
        if (kind == 0) begin
            if (rd == 0) begin
                push(run_next, rnd(), rnd(), O_EXPC);
            end else begin
                push(pick_run(mid_run), rnd(), rnd(), O_EXPC);
                push(run_next, rnd(), rnd(), O_RW);
            end
            complete(run_next);
            return;
        end
        push(pick_run(mid_run), rnd(), rnd(), O_EXPC);
        mem_o = O_DREQ | ((kind == 2) ? O_DWE : 9'h000);
        if (mw >= TIMEOUT) begin
            for (int i = 0; i < TIMEOUT; i++) push(pick_run(mid_run), rnd(), 1'b0, mem_o);
            push_error();
            return;
        end
        for (int i = 0; i < mw; i++) push(pick_run(mid_run), rnd(), 1'b0, mem_o);
        if (kind == 2) begin
            push(run_next, rnd(), 1'b1, mem_o);
        end else begin
            push(pick_run(mid_run), rnd(), 1'b1, mem_o);
            push(run_next, rnd(), rnd(), (rd != 0) ? O_RW : 9'h000);
        end
        complete(run_next);
    endtask

    task automatic run_trace(input int n);
        step_t s;
        for (int i = 0; i < n && q.size() > 0; i++) begin
            s = q.pop_front();
            @(negedge clk);
            run = s.run;
            bus.i_ready = s.i_rdy;
            bus.d_ready = s.d_rdy;
            d_load_enable = s.ld;
            d_write_enable = s.st;
            Rd = s.rd;
            #1;
            check($sformatf("outs[%0d]", step_no), 32'(obs), 32'(s.outs));
            check($sformatf("retired[%0d]", step_no), 32'(instr_retired), 32'(s.cnt));
            step_no++;
        end
    endtask

    // Asserted wherever the caller is in the cycle; outputs must drop at once.
    task automatic do_reset();
        reset_n = 1'b0;
        run = 1'b0;
        #1;
        check("reset_outs", 32'(obs), 32'd0);
        check("reset_d_req", 32'(bus.d_req), 32'd0);
        check("reset_retired", 32'(instr_retired), 32'd0);
        exp_cnt = 0;
        q.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        bus.i_ready = 1'b0;
        bus.d_ready = 1'b0;
        #2;
        do_reset();

        // Directed: ALU Rd=3, load with 3 waits, immediate store, Rd=0 op,
        // acks on the expiry cycle, run dropped mid-instruction.
        start_idle();
        gen_instr(0, 3, 0, 0, 1'b1, 1);
        gen_instr(1, 5, 0, 3, 1'b1, 2);
        gen_instr(2, 6, 0, 0, 1'b1, 2);
        gen_instr(0, 0, 0, 0, 1'b1, 2);
        gen_instr(1, 9, TIMEOUT - 1, TIMEOUT - 1, 1'b1, 2);
        gen_instr(2, 1, 1, 2, 1'b0, 0);
        for (int n = 0; n < 40; n++) begin
            gen_instr(int'($urandom_range(0, 2)),
                      ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 31)),
                      int'($urandom_range(0, TIMEOUT - 1)),
                      int'($urandom_range(0, TIMEOUT - 1)),
                      ($urandom_range(0, 3) != 0), 2);
        end
        gen_instr(0, 1, TIMEOUT, 0, 1'b1, 2);
        run_trace(q.size());
        do_reset();

        // Data-side timeout after a clean restart.
        start_idle();
        gen_instr(0, 7, 0, 0, 1'b1, 2);
        gen_instr(1, 4, 0, TIMEOUT, 1'b1, 2);
        run_trace(q.size());
        do_reset();

        // Async reset while a store is waiting in MEM.
        start_idle();
        gen_instr(0, 2, 0, 0, 1'b1, 2);
        gen_instr(2, 0, 0, 3, 1'b1, 2);
        run_trace(q.size() - 2);
        do_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
